// File: rtl/ad_sync_ctrl.sv
// ============================================================================
// Module      : ad_sync_ctrl
// Description : ADC sync controller. Issues an active-low sync pulse (manual or
//               periodic), then discards settling samples before passing data.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ad_sync_ctrl #(
    parameter int          DW    = 24,
    parameter logic [15:0] TO_US = 16'd50000
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          pluse_us,
    input  logic          syn_vld,
    input  logic          real_vld,
    input  logic [DW-1:0] real_data,
    input  logic          cfg_sync_en,
    input  logic [15:0]   cfg_period,
    input  logic [15:0]   cfg_low_us,
    input  logic [7:0]    cfg_settle,
    input  logic          err_clr,
    output logic          ad_sync_n,
    output logic [DW-1:0] out_data,
    output logic          out_vld,
    output logic          busy,
    output logic [7:0]    sync_cnt,
    output logic          err_timeout
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_SYNC_LOW = 2'd2;
    localparam logic [1:0] ST_SETTLE   = 2'd3;

    logic [1:0]    r_state;
    logic [15:0]   r_samp_cnt;
    logic [15:0]   r_us_cnt;
    logic [7:0]    r_drop_cnt;
    logic          r_ad_sync_n;
    logic [DW-1:0] r_out_data;
    logic          r_out_vld;
    logic          r_busy;
    logic [7:0]    r_sync_cnt;
    logic          r_err_timeout;

    logic [1:0]    w_state_nxt;
    logic [15:0]   w_samp_nxt;
    logic [15:0]   w_us_nxt;
    logic [7:0]    w_drop_nxt;
    logic          w_ad_sync_n_nxt;
    logic [DW-1:0] w_out_data_nxt;
    logic          w_out_vld_nxt;
    logic          w_busy_nxt;
    logic [7:0]    w_sync_cnt_nxt;
    logic          w_err_nxt;
    logic          w_set_err;

    logic [15:0]   w_low_lim;
    logic          w_period_hit;
    logic          w_low_done;
    logic          w_drop_done;
    logic          w_settle_to;
    logic          w_enter_low;

    // A programmed low time of zero still produces a one-microsecond pulse.
    assign w_low_lim    = (cfg_low_us == 16'd0) ? 16'd1 : cfg_low_us;
    assign w_period_hit = real_vld && (cfg_period != 16'd0)
                          && (r_samp_cnt == (cfg_period - 16'd1));
    assign w_low_done   = pluse_us && !syn_vld
                          && (({1'b0, r_us_cnt} + 17'd1) >= {1'b0, w_low_lim});
    assign w_drop_done  = real_vld
                          && (({1'b0, r_drop_cnt} + 9'd1) >= {1'b0, cfg_settle});
    assign w_settle_to  = !real_vld && pluse_us
                          && (({1'b0, r_us_cnt} + 17'd1) >= {1'b0, TO_US});

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_samp_cnt    <= 16'd0;
            r_us_cnt      <= 16'd0;
            r_drop_cnt    <= 8'd0;
            r_ad_sync_n   <= 1'b1;
            r_out_data    <= '0;
            r_out_vld     <= 1'b0;
            r_busy        <= 1'b0;
            r_sync_cnt    <= 8'd0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_samp_cnt    <= w_samp_nxt;
            r_us_cnt      <= w_us_nxt;
            r_drop_cnt    <= w_drop_nxt;
            r_ad_sync_n   <= w_ad_sync_n_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_vld     <= w_out_vld_nxt;
            r_busy        <= w_busy_nxt;
            r_sync_cnt    <= w_sync_cnt_nxt;
            r_err_timeout <= w_err_nxt;
        end
    end

    // Next-state: syn_vld outranks every other exit from RUN and SETTLE.
    always_comb begin
        w_state_nxt = r_state;
        if (!cfg_sync_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (syn_vld || w_period_hit)
                        w_state_nxt = ST_SYNC_LOW;
                end
                ST_SYNC_LOW: begin
                    if (w_low_done)
                        w_state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (syn_vld)
                        w_state_nxt = ST_SYNC_LOW;
                    else if (cfg_settle == 8'd0 || w_drop_done || w_settle_to)
                        w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_enter_low = (w_state_nxt == ST_SYNC_LOW) && (r_state != ST_SYNC_LOW);

    always_comb begin
        w_samp_nxt     = r_samp_cnt;
        w_us_nxt       = r_us_cnt;
        w_drop_nxt     = r_drop_cnt;
        w_out_data_nxt = r_out_data;
        w_out_vld_nxt  = 1'b0;
        w_set_err      = 1'b0;
        if (!cfg_sync_en) begin
            w_samp_nxt = 16'd0;
            w_us_nxt   = 16'd0;
            w_drop_nxt = 8'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // The sample that triggers a sync is still forwarded.
                    if (real_vld) begin
                        w_out_vld_nxt  = 1'b1;
                        w_out_data_nxt = real_data;
                        w_samp_nxt     = r_samp_cnt + 16'd1;
                    end
                    if (w_enter_low) begin
                        w_samp_nxt = 16'd0;
                        w_us_nxt   = 16'd0;
                    end
                end
                ST_SYNC_LOW: begin
                    if (syn_vld) begin
                        w_us_nxt = 16'd0;
                    end else if (w_low_done) begin
                        w_us_nxt   = 16'd0;
                        w_drop_nxt = 8'd0;
                    end else if (pluse_us) begin
                        w_us_nxt = r_us_cnt + 16'd1;
                    end
                end
                ST_SETTLE: begin
                    if (w_enter_low) begin
                        w_samp_nxt = 16'd0;
                        w_us_nxt   = 16'd0;
                        w_drop_nxt = 8'd0;
                    end else if (cfg_settle == 8'd0) begin
                        w_us_nxt   = 16'd0;
                        w_drop_nxt = 8'd0;
                    end else if (real_vld) begin
                        // Any sample arriving proves the ADC alive; restart the watchdog.
                        w_us_nxt   = 16'd0;
                        w_drop_nxt = w_drop_done ? 8'd0 : r_drop_cnt + 8'd1;
                    end else if (w_settle_to) begin
                        w_us_nxt   = 16'd0;
                        w_drop_nxt = 8'd0;
                        w_set_err  = 1'b1;
                    end else if (pluse_us) begin
                        w_us_nxt = r_us_cnt + 16'd1;
                    end
                end
                default: begin
                    w_samp_nxt = 16'd0;
                    w_us_nxt   = 16'd0;
                    w_drop_nxt = 8'd0;
                end
            endcase
        end
    end

    // Output values follow the next state so they change together with it.
    always_comb begin
        w_ad_sync_n_nxt = (w_state_nxt != ST_SYNC_LOW);
        w_busy_nxt      = (w_state_nxt == ST_SYNC_LOW) || (w_state_nxt == ST_SETTLE);
        w_sync_cnt_nxt  = (cfg_sync_en && w_enter_low) ? r_sync_cnt + 8'd1 : r_sync_cnt;
        if (w_set_err)
            w_err_nxt = 1'b1;
        else if (err_clr)
            w_err_nxt = 1'b0;
        else
            w_err_nxt = r_err_timeout;
    end

    assign ad_sync_n   = r_ad_sync_n;
    assign out_data    = r_out_data;
    assign out_vld     = r_out_vld;
    assign busy        = r_busy;
    assign sync_cnt    = r_sync_cnt;
    assign err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_ad_sync_ctrl.sv
// ============================================================================
// Module      : tb_ad_sync_ctrl
// Description : Randomized self-checking bench for ad_sync_ctrl against a
//               countdown-based behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ad_sync_ctrl;

    localparam int DW = 24;
    localparam int TO = 100;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_LOW    = 2;
    localparam int M_SETTLE = 3;

    logic          clk_sys;
    logic          rst_n;
    logic          pluse_us;
    logic          syn_vld;
    logic          real_vld;
    logic [DW-1:0] real_data;
    logic          cfg_sync_en;
    logic [15:0]   cfg_period;
    logic [15:0]   cfg_low_us;
    logic [7:0]    cfg_settle;
    logic          err_clr;
    logic          ad_sync_n;
    logic [DW-1:0] out_data;
    logic          out_vld;
    logic          busy;
    logic [7:0]    sync_cnt;
    logic          err_timeout;

    ad_sync_ctrl #(
        .DW    (DW),
        .TO_US (16'(TO))
    ) u_dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .pluse_us    (pluse_us),
        .syn_vld     (syn_vld),
        .real_vld    (real_vld),
        .real_data   (real_data),
        .cfg_sync_en (cfg_sync_en),
        .cfg_period  (cfg_period),
        .cfg_low_us  (cfg_low_us),
        .cfg_settle  (cfg_settle),
        .err_clr     (err_clr),
        .ad_sync_n   (ad_sync_n),
        .out_data    (out_data),
        .out_vld     (out_vld),
        .busy        (busy),
        .sync_cnt    (sync_cnt),
        .err_timeout (err_timeout)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: remaining low pulses / samples still to drop, counted down.
    int          m_phase;
    int          m_low_left;
    int          m_drop_left;
    int          m_quiet;
    int          m_since;
    int          m_cnt;
    bit          m_vld;
    bit          m_err;
    logic [DW-1:0] m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = M_IDLE; m_low_left = 0; m_drop_left = 0; m_quiet = 0;
        m_since = 0; m_cnt = 0; m_vld = 0; m_err = 0; m_data = '0;
    endtask

    task automatic enter_low();
        m_phase    = M_LOW;
        m_low_left = (cfg_low_us == 16'd0) ? 1 : int'(cfg_low_us);
        m_since    = 0;
        m_cnt      = (m_cnt + 1) % 256;
    endtask

    task automatic model_step();
        bit set_err;
        bit hit;
        set_err = 0;
        m_vld   = 0;
        if (!cfg_sync_en) begin
            m_phase = M_IDLE; m_since = 0; m_low_left = 0; m_drop_left = 0; m_quiet = 0;
        end else begin
            case (m_phase)
                M_IDLE: m_phase = M_RUN;
                M_RUN: begin
                    hit = real_vld && cfg_period != 0 && m_since == int'(cfg_period) - 1;
                    if (real_vld) begin
                        m_vld = 1; m_data = real_data; m_since = (m_since + 1) % 65536;
                    end
                    if (syn_vld || hit) enter_low();
                end
                M_LOW: begin
                    if (syn_vld) begin
                        m_low_left = (cfg_low_us == 16'd0) ? 1 : int'(cfg_low_us);
                    end else if (pluse_us) begin
                        m_low_left--;
                        if (m_low_left == 0) begin
                            m_phase = M_SETTLE; m_drop_left = int'(cfg_settle); m_quiet = 0;
                        end
                    end
                end
                default: begin
                    if (syn_vld) enter_low();
                    else if (m_drop_left == 0) m_phase = M_RUN;
                    else if (real_vld) begin
                        m_quiet = 0; m_drop_left--;
                        if (m_drop_left == 0) m_phase = M_RUN;
                    end else if (pluse_us) begin
                        m_quiet++;
                        if (m_quiet == TO) begin set_err = 1; m_phase = M_RUN; end
                    end
                end
            endcase
        end
        if (set_err) m_err = 1;
        else if (err_clr) m_err = 0;
    endtask

    task automatic compare_all();
        check("ad_sync_n",   32'(ad_sync_n),   32'(m_phase != M_LOW));
        check("busy",        32'(busy),        32'(m_phase == M_LOW || m_phase == M_SETTLE));
        check("out_vld",     32'(out_vld),     32'(m_vld));
        check("sync_cnt",    32'(sync_cnt),    32'(m_cnt));
        check("err_timeout", 32'(err_timeout), 32'(m_err));
        if (m_vld) check("out_data", 32'(out_data), 32'(m_data));
    endtask

    // Inputs are changed only at the falling edge; the model advances at the rising edge.
    task automatic tick();
        @(posedge clk_sys);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk_sys);
        compare_all();
    endtask

    task automatic quiet_inputs();
        syn_vld = 0; real_vld = 0; pluse_us = 0; err_clr = 0;
    endtask

    task automatic reconfig(input int period, input int low, input int settle);
        quiet_inputs();
        cfg_sync_en = 0;
        tick();
        cfg_period = 16'(period); cfg_low_us = 16'(low); cfg_settle = 8'(settle);
        cfg_sync_en = 1;
        tick();
    endtask

    task automatic rand_run(input int n, input int p_rv, input int p_pus, input int p_syn, input int p_clr);
        for (int i = 0; i < n; i++) begin
            real_vld  = ($urandom_range(0, 99) < p_rv);
            pluse_us  = ($urandom_range(0, 99) < p_pus);
            syn_vld   = ($urandom_range(0, 99) < p_syn);
            err_clr   = ($urandom_range(0, 99) < p_clr);
            real_data = DW'($urandom);
            tick();
        end
        quiet_inputs();
    endtask

    initial begin
        int issued;
        int budget;
        rst_n = 0; cfg_sync_en = 0; cfg_period = 0; cfg_low_us = 0; cfg_settle = 0;
        real_data = '0;
        quiet_inputs();
        model_reset();
        repeat (2) @(negedge clk_sys);
        compare_all();
        check("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1;

        // Periodic sync every 4 samples, 3 us low, 2 samples dropped.
        reconfig(4, 3, 2);
        rand_run(400, 30, 25, 0, 0);
        // Manual sync only, with restarts during the low time.
        reconfig(0, 6, 1);
        rand_run(400, 30, 30, 6, 0);
        // Every sample is a period trigger, so syn_vld often coincides.
        reconfig(1, 2, 1);
        rand_run(300, 50, 40, 20, 0);
        // Zero low time and zero settle count.
        reconfig(3, 0, 0);
        rand_run(200, 40, 50, 5, 0);

        // Settle watchdog: no samples, pulses every cycle.
        reconfig(0, 1, 5);
        syn_vld = 1; tick(); syn_vld = 0;
        pluse_us = 1;
        for (int i = 0; i < 130 && !m_err; i++) tick();
        pluse_us = 0;
        tick();
        check("timeout_flag", 32'(err_timeout), 32'd1);
        err_clr = 1; tick(); err_clr = 0;
        check("timeout_clear", 32'(err_timeout), 32'd0);
        // Set and clear in the same cycle: set must win.
        syn_vld = 1; tick(); syn_vld = 0;
        pluse_us = 1; err_clr = 1;
        for (int i = 0; i < 130 && !m_err; i++) tick();
        quiet_inputs();
        tick();

        // Asynchronous reset in the middle of a long low pulse.
        reconfig(0, 20, 1);
        syn_vld = 1; tick(); syn_vld = 0;
        pluse_us = 1; tick(); tick(); pluse_us = 0;
        check("low_before_rst", 32'(ad_sync_n), 32'd0);
        rst_n = 0;
        #2;
        check("async_rst_sync_n", 32'(ad_sync_n), 32'd1);
        check("async_rst_busy",   32'(busy),      32'd0);
        check("async_rst_cnt",    32'(sync_cnt),  32'd0);
        model_reset();
        @(negedge clk_sys);
        tick();
        rst_n = 1;
        tick();

        // Disable in the middle of SETTLE.
        reconfig(0, 1, 3);
        syn_vld = 1; tick(); syn_vld = 0;
        pluse_us = 1; tick(); pluse_us = 0;
        tick();
        check("in_settle", 32'(busy), 32'd1);
        cfg_sync_en = 0; tick();
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_cnt_held", 32'(sync_cnt), 32'd1);
        cfg_sync_en = 1; tick();

        // sync_cnt wrap after 256 issued syncs, starting from reset.
        rst_n = 0; @(negedge clk_sys); tick(); rst_n = 1;
        reconfig(0, 1, 0);
        pluse_us = 1;
        issued = 0;
        budget = 0;
        while (issued < 256 && budget < 3000) begin
            syn_vld = (m_phase == M_RUN || m_phase == M_SETTLE);
            if (syn_vld) issued++;
            tick();
            budget++;
        end
        quiet_inputs();
        check("wrap_budget", 32'(issued), 32'd256);
        check("sync_wrap",   32'(sync_cnt), 32'd0);

        // Soak with random configuration per segment.
        for (int s = 0; s < 6; s++) begin
            reconfig($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3));
            rand_run(300, 35, 35, 4, 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
